// File: rtl/psram_qspi_responder_if.sv
// Quad-SPI PSRAM pin bundle between the Wishbone PSRAM controller (master)
// and the device model (slave).
interface psram_qspi_responder_if;
  logic       sck;
  logic       ce_n;
  logic [3:0] din;
  logic [3:0] dout;
  logic [3:0] douten;
  logic       busy;
  logic       err;

  modport master (output sck, ce_n, din, input dout, douten, busy, err);
  modport slave  (input sck, ce_n, din, output dout, douten, busy, err);
endinterface

// File: rtl/psram_qspi_responder.sv
// QSPI PSRAM device model: EBh quad read with dummy cycles, 38h quad write,
// backed by a 2^AW byte array; sck/ce_n are sampled as clk-domain signals.
module psram_qspi_responder #(
  parameter int unsigned AW    = 12,
  parameter int unsigned DUMMY = 6
) (
  input logic                   clk,
  input logic                   rst_n,
  psram_qspi_responder_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA, ST_IGNORE
  } state_t;

  state_t          state, state_nx;
  logic            sck_q;
  logic            rise, fall;
  logic [7:0]      cnt, cnt_nx;
  logic [6:0]      cmd, cmd_nx;
  logic [7:0]      cmd_byte;
  logic            rd, rd_nx;
  logic [AW-1:0]   ptr, ptr_nx;
  logic            hi, hi_nx;
  logic [3:0]      nib_hi, nib_hi_nx;
  logic [3:0]      dout_nx, douten_nx;
  logic            busy_nx, err_nx;
  logic            we;
  logic [7:0]      rd_byte;
  logic [7:0]      mem [2**AW];

  assign rise     = bus.sck & ~sck_q;
  assign fall     = ~bus.sck & sck_q;
  assign cmd_byte = {cmd, bus.din[0]};
  assign rd_byte  = mem[ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sck_q      <= 1'b0;
      cnt        <= '0;
      cmd        <= '0;
      rd         <= 1'b0;
      ptr        <= '0;
      hi         <= 1'b1;
      nib_hi     <= '0;
      bus.dout   <= '0;
      bus.douten <= '0;
      bus.busy   <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      state      <= state_nx;
      sck_q      <= bus.sck;
      cnt        <= cnt_nx;
      cmd        <= cmd_nx;
      rd         <= rd_nx;
      ptr        <= ptr_nx;
      hi         <= hi_nx;
      nib_hi     <= nib_hi_nx;
      bus.dout   <= dout_nx;
      bus.douten <= douten_nx;
      bus.busy   <= busy_nx;
      bus.err    <= err_nx;
    end
  end

  // Array has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) mem[ptr] <= {nib_hi, bus.din};
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    cmd_nx    = cmd;
    rd_nx     = rd;
    ptr_nx    = ptr;
    hi_nx     = hi;
    nib_hi_nx = nib_hi;
    dout_nx   = bus.dout;
    err_nx    = 1'b0;
    we        = 1'b0;

    if (bus.ce_n) begin
      // Deselect overrides any sck edge seen on the same clk.
      state_nx = ST_IDLE;
      cnt_nx   = '0;
      hi_nx    = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_nx = ST_CMD;
          cnt_nx   = '0;
        end
        ST_CMD: if (rise) begin
          cmd_nx = cmd_byte[6:0];
          if (cnt == 8'd7) begin
            cnt_nx = '0;
            if (cmd_byte == 8'hEB) begin
              state_nx = ST_ADDR;
              rd_nx    = 1'b1;
            end else if (cmd_byte == 8'h38) begin
              state_nx = ST_ADDR;
              rd_nx    = 1'b0;
            end else begin
              state_nx = ST_IGNORE;
              err_nx   = 1'b1;
            end
          end else begin
            cnt_nx = cnt + 8'd1;
          end
        end
        ST_ADDR: if (rise) begin
          // ptr doubles as the address shifter; bits above AW fall off the top.
          ptr_nx = AW'({ptr, bus.din});
          if (cnt == 8'd5) begin
            cnt_nx = '0;
            hi_nx  = 1'b1;
            if (!rd)             state_nx = ST_WDATA;
            else if (DUMMY == 0) state_nx = ST_RDATA;
            else                 state_nx = ST_DUMMY;
          end else begin
            cnt_nx = cnt + 8'd1;
          end
        end
        ST_DUMMY: if (rise) begin
          if (cnt == 8'(DUMMY - 1)) begin
            cnt_nx   = '0;
            state_nx = ST_RDATA;
          end else begin
            cnt_nx = cnt + 8'd1;
          end
        end
        ST_RDATA: if (fall) begin
          dout_nx = hi ? rd_byte[7:4] : rd_byte[3:0];
          if (!hi) ptr_nx = ptr + AW'(1);
          hi_nx = ~hi;
        end
        ST_WDATA: if (rise) begin
          if (hi) begin
            nib_hi_nx = bus.din;
          end else begin
            we     = 1'b1;
            ptr_nx = ptr + AW'(1);
          end
          hi_nx = ~hi;
        end
        ST_IGNORE: ;
        default: state_nx = ST_IDLE;
      endcase
    end

    douten_nx = (state_nx == ST_RDATA) ? '1 : '0;
    busy_nx   = (state_nx != ST_IDLE);
  end

endmodule

// File: tb/tb_psram_qspi_responder.sv
// Directed bench for psram_qspi_responder: a DUMMY=6 and a DUMMY=4 instance
// driven by a behavioural QSPI master (sck half-period = 2 clk).
module tb_psram_qspi_responder;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck   = 1'b0;
  logic       ce_n  = 1'b1;
  logic [3:0] din   = 4'h0;
  logic       sel   = 1'b0;
  int         tests = 0;
  int         fails = 0;
  int         err_cnt = 0;
  int         douten_cnt = 0;

  always #5 clk = ~clk;

  psram_qspi_responder_if b0 ();
  psram_qspi_responder_if b1 ();

  assign b0.sck  = sel ? 1'b0 : sck;
  assign b0.ce_n = sel ? 1'b1 : ce_n;
  assign b0.din  = din;
  assign b1.sck  = sel ? sck  : 1'b0;
  assign b1.ce_n = sel ? ce_n : 1'b1;
  assign b1.din  = din;

  psram_qspi_responder #(.AW(12), .DUMMY(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0.slave)
  );

  psram_qspi_responder #(.AW(12), .DUMMY(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  logic [3:0] dout_o, douten_o;
  logic       busy_o, err_o;
  assign dout_o   = sel ? b1.dout   : b0.dout;
  assign douten_o = sel ? b1.douten : b0.douten;
  assign busy_o   = sel ? b1.busy   : b0.busy;
  assign err_o    = sel ? b1.err    : b0.err;

  always @(posedge clk) if (err_o) err_cnt <= err_cnt + 1;
  always @(negedge clk) if (douten_o != 4'h0) douten_cnt <= douten_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sck cycle: low half then high half; q is dout as seen at the rise.
  task automatic sck_cyc(input logic [3:0] d, output logic [3:0] q);
    @(negedge clk); sck = 1'b0; din = d;
    @(negedge clk);
    @(negedge clk); q = dout_o; sck = 1'b1;
    @(negedge clk);
  endtask

  task automatic begin_txn();
    @(negedge clk); ce_n = 1'b0; sck = 1'b0;
    @(negedge clk);
  endtask

  task automatic end_txn();
    ce_n = 1'b1; sck = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] q;
    for (int i = 7; i >= 0; i--) sck_cyc({3'b000, b[i]}, q);
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [3:0] q;
    for (int i = 5; i >= 0; i--) sck_cyc(a[i*4 +: 4], q);
  endtask

  task automatic idle_cyc(input int n, input logic [3:0] d);
    logic [3:0] q;
    repeat (n) sck_cyc(d, q);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    logic [3:0] q;
    sck_cyc(b[7:4], q);
    sck_cyc(b[3:0], q);
  endtask

  task automatic read_nib(input string tag, input logic [3:0] exp);
    logic [3:0] q;
    sck_cyc(4'h0, q);
    check(tag, {28'd0, q}, {28'd0, exp});
    check({tag, "_oe"}, {28'd0, douten_o}, 32'hF);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, d0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_dout",   {28'd0, dout_o},   32'h0);
    check("rst_douten", {28'd0, douten_o}, 32'h0);
    check("rst_busy",   {31'd0, busy_o},   32'h0);
    check("rst_err",    {31'd0, err_o},    32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write A5,3C at 010h then read 4 nibbles back
    begin_txn();
    check("wr_busy", {31'd0, busy_o}, 32'h1);
    send_byte(8'h38);
    send_addr(24'h000010);
    wr_byte(8'hA5);
    wr_byte(8'h3C);
    end_txn();
    check("wr_idle_busy", {31'd0, busy_o}, 32'h0);

    begin_txn();
    send_byte(8'hEB);
    send_addr(24'h000010);
    check("rd_addr_oe", {28'd0, douten_o}, 32'h0);
    idle_cyc(6, 4'h0);
    read_nib("rd_n0", 4'hA);
    read_nib("rd_n1", 4'h5);
    read_nib("rd_n2", 4'h3);
    read_nib("rd_n3", 4'hC);
    end_txn();
    check("rd_end_oe", {28'd0, douten_o}, 32'h0);

    // Wrap: 11h at FFFh, 22h at 000h
    begin_txn();
    send_byte(8'h38);
    send_addr(24'h000FFF);
    wr_byte(8'h11);
    wr_byte(8'h22);
    end_txn();
    begin_txn();
    send_byte(8'hEB);
    send_addr(24'h000FFF);
    idle_cyc(6, 4'h0);
    read_nib("wrap_n0", 4'h1);
    read_nib("wrap_n1", 4'h1);
    read_nib("wrap_n2", 4'h2);
    read_nib("wrap_n3", 4'h2);
    end_txn();

    // Upper address bits alias: 001010h reads byte at 010h
    begin_txn();
    send_byte(8'hEB);
    send_addr(24'h001010);
    idle_cyc(6, 4'h0);
    read_nib("alias_n0", 4'hA);
    read_nib("alias_n1", 4'h5);
    end_txn();

    // Abort mid-byte: pre-load 20h/21h, then 38h @20h with nibbles 7,8,9
    begin_txn();
    send_byte(8'h38);
    send_addr(24'h000020);
    wr_byte(8'h00);
    wr_byte(8'h5A);
    end_txn();
    begin_txn();
    send_byte(8'h38);
    send_addr(24'h000020);
    wr_byte(8'h78);
    idle_cyc(1, 4'h9);
    check("abort_busy_before", {31'd0, busy_o}, 32'h1);
    ce_n = 1'b1; sck = 1'b0;
    @(negedge clk);
    check("abort_busy_after", {31'd0, busy_o}, 32'h0);
    @(negedge clk);
    begin_txn();
    send_byte(8'hEB);
    send_addr(24'h000020);
    idle_cyc(6, 4'h0);
    read_nib("abort_n0", 4'h7);
    read_nib("abort_n1", 4'h8);
    read_nib("abort_n2", 4'h5);
    read_nib("abort_n3", 4'hA);
    end_txn();

    // Unknown command 05h followed by 20 sck cycles with din = F
    e0 = err_cnt;
    d0 = douten_cnt;
    begin_txn();
    send_byte(8'h05);
    check("unk_err_pulse", {31'd0, err_o}, 32'h1);
    @(negedge clk);
    check("unk_err_clear", {31'd0, err_o}, 32'h0);
    idle_cyc(20, 4'hF);
    end_txn();
    check("unk_err_count", err_cnt - e0, 32'd1);
    check("unk_no_drive", douten_cnt - d0, 32'd0);
    begin_txn();
    send_byte(8'hEB);
    send_addr(24'h000020);
    idle_cyc(6, 4'h0);
    read_nib("unk_mem_n0", 4'h7);
    read_nib("unk_mem_n1", 4'h8);
    end_txn();

    // Reset asserted during RDATA
    begin_txn();
    send_byte(8'hEB);
    send_addr(24'h000010);
    idle_cyc(6, 4'h0);
    read_nib("rrst_n0", 4'hA);
    #1 rst_n = 1'b0;
    #1;
    check("rrst_dout",   {28'd0, dout_o},   32'h0);
    check("rrst_douten", {28'd0, douten_o}, 32'h0);
    check("rrst_busy",   {31'd0, busy_o},   32'h0);
    ce_n = 1'b1; sck = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    begin_txn();
    send_byte(8'hEB);
    send_addr(24'h000010);
    idle_cyc(6, 4'h0);
    read_nib("rrst_after_n0", 4'hA);
    read_nib("rrst_after_n1", 4'h5);
    end_txn();

    // DUMMY = 4 instance: write C3h at 000h, read it back
    sel = 1'b1;
    @(negedge clk);
    begin_txn();
    send_byte(8'h38);
    send_addr(24'h000000);
    wr_byte(8'hC3);
    end_txn();
    begin_txn();
    send_byte(8'hEB);
    send_addr(24'h000000);
    idle_cyc(3, 4'h0);
    check("d4_oe_3rd", {28'd0, douten_o}, 32'h0);
    idle_cyc(1, 4'h0);
    check("d4_oe_4th", {28'd0, douten_o}, 32'hF);
    read_nib("d4_n0", 4'hC);
    read_nib("d4_n1", 4'h3);
    end_txn();
    sel = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/psram_qspi_responder.md
# psram_qspi_responder

Synthesizable QSPI PSRAM device model that answers the commands issued by the team's Wishbone PSRAM controller: EBh quad read (with dummy cycles) and 38h quad write. It sits on the controller's external pins (sck, ce_n, quad data) in simulation and FPGA test builds, backed by a byte-wide internal array. It shares the controller's system clock, and treats sck and ce_n as same-domain registered signals.

## Interface

Parameters:
- AW, 12: byte-address width of the internal array (2^AW bytes); upper address bits alias.
- DUMMY, 6: sck rising edges between the last address nibble and the first read nibble.

Ports:
- clk  input  1  system clock, the same clock that drives the controller.
- rst_n  input  1  asynchronous, active-low reset.
- sck  input  1  serial clock from the controller; a registered output in the clk domain, with half-period ≥ 1 clk.
- ce_n  input  1  chip enable, active low.
- din  input  4  quad data from the controller (controller dout).
- dout  output  4  quad data to the controller (controller din).
- douten  output  4  output enable; all ones while driving read data, otherwise 0.
- busy  output  1  high while ce_n is low and state ≠ IDLE.
- err  output  1  one-clk pulse when an unsupported command byte completes.

## Operation

- Edge detect: sck_q holds sck from the previous clk.
  - rise = sck & ~sck_q.
  - fall = ~sck & sck_q.
  - No synchronizers are used.
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
- IDLE: when ce_n is low → CMD, with bit counter = 0.
- CMD: on each rise, shift din[0] in, MSB first. After the 8th rise:
  - EBh → ADDR with rd flag set.
  - 38h → ADDR with rd flag clear.
  - Any other value → IGNORE, and pulse err.
- ADDR: on each rise, shift in din[3:0], MSB nibble first, 6 nibbles into a 24-bit address. After the 6th rise:
  - rd → DUMMY.
  - !rd → WDATA.
- DUMMY: count DUMMY rises, then → RDATA. A pointer ptr = addr[AW-1:0] and a nibble flag hi = 1.
- RDATA, read side:
  - douten = 4'hF.
  - On each fall, dout is loaded with mem[ptr][7:4] if hi, otherwise mem[ptr][3:0].
  - After loading the low nibble, ptr increments, then hi toggles.
  - The first load occurs on the first fall after entering RDATA.
- WDATA, write side:
  - On each rise with hi = 1, latch din into nib_hi.
  - On each rise with hi = 0, write mem[ptr] = {nib_hi, din}, then ptr increments.
  - hi toggles on every rise.
- ptr wraps modulo 2^AW (2^AW−1 → 0). Address bits [23:AW] are ignored.
- IGNORE: no drive and no writes until ce_n goes high.
- ce_n high on any clk, from any state → IDLE on that edge:
  - douten = 0, counters cleared.
  - A pending high nibble with no low nibble is discarded; no partial write occurs.
- Simultaneous ce_n high and a sck edge: ce_n wins; the edge is not acted on.
- Memory contents are not reset; they are retained across rst_n.

## Timing

- Reset values: dout = 0, douten = 0, busy = 0, err = 0, state = IDLE, sck_q = 0.
- Outputs are registered.
  - A fall detected at clk edge n updates dout at edge n.
  - The controller sees the value from edge n+1 onward, one sck half-period before the next rise.
- Write commit: the memory write occurs at the clk edge where the second-nibble rise is detected. A read in a later transaction observes it.
- busy goes high the first clk after ce_n is sampled low. It goes low at the edge ce_n is sampled high.
- err asserts for exactly 1 clk, at the edge of the 8th command rise.
- Minimum transaction lengths, in sck cycles:
  - Read of N bytes: 8 + 6 + DUMMY + 2N.
  - Write of N bytes: 8 + 6 + 2N.

## Test plan

- Write then read:
  - Stimulus: 38h, addr 000010h, bytes A5h, 3Ch; ce_n high; then EBh, addr 000010h, 4 nibbles.
  - Required: dout sequence A, 5, 3, C, and douten = F only during RDATA.
- Wrap-around:
  - Stimulus (AW = 12): write 11h at FFFh and 22h at 000h via a 2-byte write from 000FFFh; then read 2 bytes from 000FFFh.
  - Required: 1, 1, 2, 2. A read at 001010h returns the byte at 010h.
- Abort mid-byte:
  - Stimulus: 38h, addr 20h, nibbles 7, 8, 9, then ce_n high.
  - Required: mem[20h] = 78h; mem[21h] is unchanged; busy falls the same clk ce_n is sampled high.
- Unknown command:
  - Stimulus: command 05h followed by 20 sck cycles.
  - Required: err pulses once at the 8th rise; douten stays 0; no memory change.
- Reset mid-read:
  - Stimulus: assert rst_n low during RDATA.
  - Required: dout = 0, douten = 0, and busy = 0 immediately (asynchronously); memory retained; the next EBh transaction reads correctly.
- DUMMY parameter:
  - Stimulus: set DUMMY = 4 and read byte C3h.
  - Required: the first driven nibble (C) appears after the 4th post-address rise, then 3.
